// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM states and seed-mixing helpers for lfsr_bank and lfsr_lane.
package lfsr_pkg;
    localparam int MAX_W = 64;
    typedef enum logic [1:0] {S_WAIT_SEED, S_WARM, S_RUN} state_t;
    // Caller zero-extends v, so only the low w bits are reversed into the low w bits.
    function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] v, input int unsigned w);
        logic [MAX_W-1:0] r;
        r = {<<{v}};
        return r >> (MAX_W - w);
    endfunction
    function automatic logic [MAX_W-1:0] lane_mix(input logic [MAX_W-1:0] seed, input int unsigned k, input int unsigned w);
        logic [MAX_W-1:0] m;
        m = (k % 3 == 0) ? seed : (k % 3 == 1) ? ~seed : bit_rev(seed, w);
        return m ^ MAX_W'(k);
    endfunction
endpackage

// File: rtl/lfsr_lane.sv
// lfsr_lane: one Fibonacci LFSR register with seed load, zero-lock recovery and sticky stuck flag.
module lfsr_lane #(
    parameter int LANE_W = 11,
    parameter int TAP_HI = 9,
    parameter int TAP_LO = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [LANE_W-1:0] i_seed,
    input  logic              i_step,
    output logic [LANE_W-1:0] o_q,
    output logic              o_stuck
);
    logic [LANE_W-1:0] r_q;
    logic              r_stuck;
    logic              w_zero;
    assign w_zero  = (r_q == '0);
    assign o_q     = r_q;
    assign o_stuck = r_stuck;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= LANE_W'(1);
            r_stuck <= 1'b0;
        end else if (i_load) begin
            r_q     <= (i_seed == '0) ? LANE_W'(1) : i_seed;
            r_stuck <= 1'b0;
        end else if (i_step) begin
            r_q     <= w_zero ? LANE_W'(1) : {r_q[LANE_W-2:0], r_q[TAP_HI] ^ r_q[TAP_LO]};
            r_stuck <= r_stuck | w_zero;
        end
    end
endmodule

// File: rtl/lfsr_bank.sv
// lfsr_bank: bank of LANES seeded LFSR lanes with warm-up FSM and valid/ready output.
// Define LFSR_BANK_FREERUN_EN to step lanes every cycle in S_RUN regardless of rand_ready.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int LANE_W = 11,
    parameter int LANES  = 3,
    parameter int TAP_HI = 9,
    parameter int TAP_LO = 6,
    parameter int WARMUP = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANE_W-1:0]       seed_i,
    input  logic                    seed_valid,
    output logic                    seed_ready,
    output logic [LANES*LANE_W-1:0] rand_o,
    output logic                    rand_valid,
    input  logic                    rand_ready,
    output logic [LANES-1:0]        lane_stuck
);
    if (LANE_W < 3 || LANE_W > MAX_W || TAP_HI >= LANE_W || TAP_LO >= TAP_HI || TAP_LO < 0 ||
        LANES < 1 || WARMUP < 0 || WARMUP > 255) begin : g_bad_params
        $error("lfsr_bank: illegal LANE_W/TAP_HI/TAP_LO/LANES/WARMUP");
    end
    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_seed_ready;
    logic       r_rand_valid;
    logic       w_load;
    logic       w_take;
    logic       w_step;
    assign seed_ready = r_seed_ready;
    assign rand_valid = r_rand_valid;
    assign w_load     = seed_valid & r_seed_ready & (seed_i != '0);
`ifdef LFSR_BANK_FREERUN_EN
    assign w_take = 1'b1;
`else
    assign w_take = rand_ready;
`endif
    // A reseed overrides any step in the same cycle.
    assign w_step = ~w_load & ((r_state == S_WARM) | ((r_state == S_RUN) & w_take));
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_WAIT_SEED;
            r_cnt        <= '0;
            r_seed_ready <= 1'b1;
            r_rand_valid <= 1'b0;
        end else if (w_load) begin
            r_state      <= (WARMUP == 0) ? S_RUN : S_WARM;
            r_cnt        <= 8'(WARMUP);
            r_seed_ready <= (WARMUP == 0);
            r_rand_valid <= (WARMUP == 0);
        end else if (r_state == S_WARM) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
                r_state      <= S_RUN;
                r_seed_ready <= 1'b1;
                r_rand_valid <= 1'b1;
            end
        end
    end
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LANE_W-1:0] w_mix;
        assign w_mix = LANE_W'(lane_mix(MAX_W'(seed_i), k, LANE_W));
        lfsr_lane #(.LANE_W(LANE_W), .TAP_HI(TAP_HI), .TAP_LO(TAP_LO)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load),
            .i_seed (w_mix),
            .i_step (w_step),
            .o_q    (rand_o[k*LANE_W +: LANE_W]),
            .o_stuck(lane_stuck[k])
        );
    end
endmodule

// File: tb/tb_lfsr_bank.sv
// tb_lfsr_bank: two lfsr_bank instances (WARMUP 0 and 4) against a behavioural lane model.
module tb_lfsr_bank;
    localparam int LANE_W = 11;
    localparam int LANES  = 3;
    localparam int TAP_HI = 9;
    localparam int TAP_LO = 6;
    localparam int MASK   = (1 << LANE_W) - 1;
`ifdef LFSR_BANK_FREERUN_EN
    localparam bit FREE = 1'b1;
`else
    localparam bit FREE = 1'b0;
`endif
    logic                    clk = 1'b0;
    logic                    reset;
    logic                    seed_valid;
    logic                    rand_ready;
    logic [LANE_W-1:0]       seed_i;
    logic [LANES*LANE_W-1:0] rand_o     [2];
    logic                    rand_valid [2];
    logic                    seed_ready [2];
    logic [LANES-1:0]        lane_stuck [2];
    int n_checks = 0;
    int n_errors = 0;
    // Model state per instance: state 0 = waiting for seed, 1 = warming, 2 = running.
    int m_lane  [2][LANES];
    bit m_stuck [2][LANES];
    int m_state [2];
    int m_left  [2];
    always #5 clk = ~clk;
    lfsr_bank #(.LANE_W(LANE_W), .LANES(LANES), .TAP_HI(TAP_HI), .TAP_LO(TAP_LO), .WARMUP(0)) dut0 (
        .clk(clk), .reset(reset), .seed_i(seed_i), .seed_valid(seed_valid), .seed_ready(seed_ready[0]),
        .rand_o(rand_o[0]), .rand_valid(rand_valid[0]), .rand_ready(rand_ready), .lane_stuck(lane_stuck[0]));
    lfsr_bank #(.LANE_W(LANE_W), .LANES(LANES), .TAP_HI(TAP_HI), .TAP_LO(TAP_LO), .WARMUP(4)) dut4 (
        .clk(clk), .reset(reset), .seed_i(seed_i), .seed_valid(seed_valid), .seed_ready(seed_ready[1]),
        .rand_o(rand_o[1]), .rand_valid(rand_valid[1]), .rand_ready(rand_ready), .lane_stuck(lane_stuck[1]));
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int mix(int s, int k);
        int m = 0;
        if (k % 3 == 0) m = s;
        else if (k % 3 == 1) m = ~s & MASK;
        else for (int i = 0; i < LANE_W; i++) if (s[i]) m |= 1 << (LANE_W - 1 - i);
        return (m ^ k) & MASK;
    endfunction
    task automatic model_edge(int d);
        int  w    = d * 4;
        bit  warm = (m_state[d] == 1);
        bit  run  = (m_state[d] == 2);
        int  v;
        if (reset) begin
            for (int k = 0; k < LANES; k++) begin m_lane[d][k] = 1; m_stuck[d][k] = 0; end
            m_state[d] = 0;
            m_left[d]  = 0;
        end else if (seed_valid && !warm && seed_i != 0) begin
            for (int k = 0; k < LANES; k++) begin
                v = mix(int'(seed_i), k);
                m_lane[d][k]  = (v == 0) ? 1 : v;
                m_stuck[d][k] = 0;
            end
            m_state[d] = (w == 0) ? 2 : 1;
            m_left[d]  = w;
        end else begin
            if (warm || (run && (FREE || rand_ready)))
                for (int k = 0; k < LANES; k++) begin
                    v = m_lane[d][k];
                    if (v == 0) begin m_lane[d][k] = 1; m_stuck[d][k] = 1; end
                    else m_lane[d][k] = ((v << 1) | (((v >> TAP_HI) ^ (v >> TAP_LO)) & 1)) & MASK;
                end
            if (warm) begin
                m_left[d]--;
                if (m_left[d] == 0) m_state[d] = 2;
            end
        end
    endtask
    function automatic logic [63:0] exp_rand(int d);
        logic [63:0] r = '0;
        for (int k = 0; k < LANES; k++) r |= 64'(m_lane[d][k]) << (k * LANE_W);
        return r;
    endfunction
    function automatic logic [63:0] exp_stuck(int d);
        logic [63:0] r = '0;
        for (int k = 0; k < LANES; k++) r[k] = m_stuck[d][k];
        return r;
    endfunction
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rand_o[w%0d]", d * 4), 64'(rand_o[d]), exp_rand(d));
            check($sformatf("rand_valid[w%0d]", d * 4), 64'(rand_valid[d]), 64'(m_state[d] == 2));
            check($sformatf("seed_ready[w%0d]", d * 4), 64'(seed_ready[d]), 64'(m_state[d] != 1));
            check($sformatf("lane_stuck[w%0d]", d * 4), 64'(lane_stuck[d]), exp_stuck(d));
        end
    endtask
    initial begin
        logic [LANES*LANE_W-1:0] prev;
        logic [LANES*LANE_W-1:0] ones;
        int lo = 0;
        int first = 0;
        ones = {11'h001, 11'h001, 11'h001};
        reset = 1'b1; seed_valid = 1'b0; seed_i = '0; rand_ready = 1'b0;
        tick();
        tick();
        check("reset_rand", 64'(rand_o[0]), 64'(ones));
        check("reset_valid", 64'(rand_valid[0]), 64'd0);
        check("reset_ready", 64'(seed_ready[1]), 64'd1);
        reset = 1'b0; seed_valid = 1'b1; seed_i = '0;
        tick();
        check("zero_seed_rand", 64'(rand_o[0]), 64'(ones));
        check("zero_seed_valid", 64'(rand_valid[1]), 64'd0);
        seed_i = 11'h001;
        tick();
        check("load_rand", 64'(rand_o[0]), 64'({11'h402, 11'h7FF, 11'h001}));
        check("load_valid", 64'(rand_valid[0]), 64'd1);
        if (!seed_ready[1]) lo++;
        if (rand_valid[1] && first == 0) first = 1;
        seed_valid = 1'b0;
        prev = {11'h004, 11'h7FE, 11'h002};
        for (int c = 2; c <= 7; c++) begin
            rand_ready = (c == 2);
            tick();
            if (c == 2) check("step_rand", 64'(rand_o[0]), 64'(prev));
            else begin
`ifdef LFSR_BANK_FREERUN_EN
                check("free_change", 64'(rand_o[0] != prev), 64'd1);
`else
                check("bp_hold", 64'(rand_o[0]), 64'(prev));
`endif
                check("bp_valid", 64'(rand_valid[0]), 64'd1);
            end
            prev = rand_o[0];
            if (!seed_ready[1]) lo++;
            if (rand_valid[1] && first == 0) first = c;
        end
        check("warm_ready_low", 64'(lo), 64'd4);
        check("warm_latency", 64'(first), 64'd5);
        seed_i = 11'h400; seed_valid = 1'b1; rand_ready = 1'b0;
        tick();
        check("zl_load", 64'(rand_o[0][LANE_W-1:0]), 64'h400);
        seed_valid = 1'b0; rand_ready = 1'b1;
        tick();
        check("zl_zero", 64'(rand_o[0][LANE_W-1:0]), 64'h000);
        tick();
        check("zl_one", 64'(rand_o[0][LANE_W-1:0]), 64'h001);
        check("zl_stuck", 64'(lane_stuck[0][0]), 64'd1);
        seed_i = 11'h123; seed_valid = 1'b1;
        tick();
        check("zl_clear", 64'(lane_stuck[0][0]), 64'd0);
        seed_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_ready = 1'($urandom_range(0, 1));
            tick();
        end
        seed_i = 11'h2A5; seed_valid = 1'b1; rand_ready = 1'b1;
        tick();
        check("collide_rand", 64'(rand_o[0]), 64'({11'(mix(32'h2A5, 2)), 11'(mix(32'h2A5, 1)), 11'(mix(32'h2A5, 0))}));
        check("collide_drop", 64'(rand_valid[1]), 64'd0);
        seed_i = 11'h055;
        tick();
        seed_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midwarm_rand", 64'(rand_o[1]), 64'(ones));
        check("midwarm_ready", 64'(seed_ready[1]), 64'd1);
        check("midwarm_valid", 64'(rand_valid[1]), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            seed_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 7))
                0:       seed_i = '0;
                1:       seed_i = 11'h400;
                default: seed_i = LANE_W'($urandom_range(1, MASK));
            endcase
            rand_ready = 1'($urandom_range(0, 1));
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
